rr_grant_arbiter: RTL
=====================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Builds a rotating-priority encoder around a pointer register and holds each grant until the owner signals completion.
- Sits between request sources and a single shared datapath. The resource reads grant_id to steer its input mux and returns done when a transaction finishes.

Parameters:
N, 8, number of requesters; legal range 2..16.
IDW, 3, grant_id width; must equal ceil(log2(N)); elaboration error otherwise.
MAX_HOLD, 15, max consecutive BUSY cycles per grant; used only with ARB_TIMEOUT_EN; legal 1..255.

Ports:
clk  input  1  rising-edge clock
areset_n  input  1  asynchronous active-low reset
req  input  N  per-requester request level, bit i = requester i
done  input  1  single-cycle pulse from resource: current transaction complete
grant  output  N  one-hot grant, registered; all-zero when idle
grant_id  output  IDW  binary index of granted requester, registered
grant_valid  output  1  high while any grant is held, registered
timeout  output  1  single-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset:
  - Asynchronous assert, synchronous-style deassert handled upstream.
  - grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=0, state=IDLE, hold counter=0.
- States:
  - IDLE: no grant held.
  - BUSY: one grant held.
- Priority search: circular scan of req starting at index ptr, upward, wrapping N-1 -> 0. The first set bit wins. Combinational; result is registered.
- IDLE:
  - If req!=0, the winner is registered next edge: grant=onehot(w), grant_id=w, grant_valid=1, state=BUSY.
  - Latency from req rising to grant is exactly 1 cycle.
  - If req==0, stay IDLE; outputs remain 0.
- BUSY:
  - Grant is held unchanged while req[grant_id]=1 and done=0.
  - Release condition: done=1, or req[grant_id]=0 (requester withdrew).
  - On release: ptr <= (grant_id+1) mod N. Arbitration for the next grant runs in the same cycle using the new pointer value, so the current owner is lowest priority.
    - If any req bit remains set (owner excluded when release was by withdrawal), the next grant is registered on the same edge: zero-bubble back-to-back, state stays BUSY.
    - Otherwise grant=0, grant_valid=0, state=IDLE.
  - A sole requester that pulses done while still requesting is re-granted back-to-back. grant_id is unchanged and grant_valid stays 1.
- done while IDLE is ignored. done and req[grant_id] falling in the same cycle count as one release.
- Requests of non-owners may change freely during BUSY and do not disturb the grant.
- Wrap-around: grant_id=N-1 releases -> ptr=0.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id matches the grant bit position when valid.
- Reset asserted mid-BUSY: all outputs clear immediately, without waiting for a clock edge. The pointer returns to 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on every new grant (including a re-grant) and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD with no release, the grant is force-released: same pointer advance and back-to-back rules as a normal release.
  - timeout pulses high for exactly the one cycle in which the forced release is registered.
- Not defined:
  - No counter is instantiated; grants are held indefinitely.
  - timeout is driven constant 0.

Test Plan:
1. Reset then req=8'b0000_0000 for 5 cycles -> grant=0, grant_valid=0, grant_id=0 throughout.
2. req=8'b1001_0000 from IDLE with ptr=0 -> one cycle later grant=8'b0001_0000, grant_id=4. Then done pulse with req held -> next edge grant=8'b1000_0000, grant_id=7, ptr=5, no idle cycle.
3. req=8'hFF held, done pulsed every cycle -> grant_id sequence 0,1,2,...,7,0 (wrap). grant_valid never drops.
4. Grant held on id 3, requester 3 drops req while req=8'b0000_0000 otherwise -> next edge grant=0, grant_valid=0, ptr=4. A later req=8'b0000_1001 -> grant_id=0, since the scan from 4 wraps to 0.
5. Grant held on id 5, areset_n pulsed low mid-BUSY -> grant/grant_id/grant_valid read 0 before the next clk edge. After release with req=8'b0000_0100 -> grant_id=2 one cycle later.
6. ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=8'b0000_0011 held, no done -> id 0 held 4 BUSY cycles, then timeout=1 for one cycle and grant_id=1. Without the macro -> id 0 held indefinitely, timeout=0.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with rotating priority and grant-until-done hold.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           areset_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_grant_arbiter: N must be in 2..16");
    end
    if (IDW != $clog2(N)) begin : g_bad_idw
        $error("rr_grant_arbiter: IDW must equal clog2(N)");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_grant_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] ptr_adv;
    logic [IDW-1:0] scan_start;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           normal_rel;
    logic           force_rel;
    logic           release_now;
    logic           load;
    logic [N-1:0]   grant_nxt;
    logic [IDW-1:0] id_nxt;
    logic           valid_nxt;

    assign ptr_adv     = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    assign normal_rel  = (state == BUSY) && (done || !req[grant_id]);
    assign release_now = normal_rel || force_rel;

    // On release the scan already starts past the owner, so it ends up lowest priority.
    assign scan_start = (state == BUSY) ? ptr_adv : ptr;

    always_comb begin : scan
        logic [IDW:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, scan_start} + (IDW + 1)'(i);
            if (idx >= (IDW + 1)'(N)) begin
                idx = idx - (IDW + 1)'(N);
            end
            if (!win_found && req[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        id_nxt    = grant_id;
        valid_nxt = grant_valid;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nxt = ptr_adv;
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        id_nxt    = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (load) begin
            state_nxt = BUSY;
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << win_id;
            id_nxt    = win_id;
            valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            grant_id    <= id_nxt;
            grant_valid <= valid_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // Counter value equals the number of busy cycles already spent by the current grant.
    assign force_rel = (state == BUSY) && !normal_rel && (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (load || state != BUSY) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule
